// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// The fetch unit is the master; the memory answers with a single-cycle ack strobe.
interface if_fetch_unit_if #(
  parameter int BUS_W = 32
);
  logic             imemReqOut;
  logic [BUS_W-1:0] imemAddrOut;
  logic             imemAckIn;
  logic [BUS_W-1:0] imemDataIn;

  modport master (
    output imemReqOut,
    output imemAddrOut,
    input  imemAckIn,
    input  imemDataIn
  );

  modport slave (
    input  imemReqOut,
    input  imemAddrOut,
    output imemAckIn,
    output imemDataIn
  );
endinterface

// File: rtl/if_fetch_unit.sv
// RVX instruction-fetch stage: owns the PC, issues imem requests and loads IF/ID.
// A one-entry skid buffer holds a response that lands while IF is stalled.
module if_fetch_unit #(
  parameter int               BUS_W    = 32,
  parameter logic [BUS_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [BUS_W-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallIFIn,
  input  logic               flushIFIn,
  input  logic               jumpEnIn,
  input  logic [BUS_W-1:0]   jumpAddrIn,
  if_fetch_unit_if.master    imem,
  output logic [BUS_W-1:0]   instOut_IFID,
  output logic [BUS_W-1:0]   pcOut_IFID,
  output logic               validOut_IFID
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [BUS_W-1:0] pc, pc_next;
  logic [BUS_W-1:0] req_addr, req_addr_next;
  logic             buf_valid, buf_valid_next;
  logic [BUS_W-1:0] buf_inst, buf_inst_next;
  logic [BUS_W-1:0] buf_pc, buf_pc_next;
  logic             load_en;
  logic [BUS_W-1:0] load_inst, load_pc;
  logic [BUS_W-1:0] jump_target, pc_inc;

  assign jump_target = jumpAddrIn & ~BUS_W'(3);
  assign pc_inc      = pc + BUS_W'(4);

  // Withdraw the request combinationally while reset is held.
  assign imem.imemReqOut  = rst && (state != IDLE);
  assign imem.imemAddrOut = req_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= REQ;
      pc        <= RESET_PC;
      req_addr  <= RESET_PC;
      buf_valid <= 1'b0;
      buf_inst  <= NOP_INST;
      buf_pc    <= '0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      req_addr  <= req_addr_next;
      buf_valid <= buf_valid_next;
      buf_inst  <= buf_inst_next;
      buf_pc    <= buf_pc_next;
    end
  end

  always_comb begin
    state_next     = state;
    pc_next        = pc;
    req_addr_next  = req_addr;
    buf_valid_next = buf_valid;
    buf_inst_next  = buf_inst;
    buf_pc_next    = buf_pc;
    load_en        = 1'b0;
    load_inst      = NOP_INST;
    load_pc        = '0;

    if (jumpEnIn) begin
      buf_valid_next = 1'b0;
    end

    case (state)
      REQ: begin
        if (imem.imemAckIn) begin
          if (jumpEnIn) begin
            pc_next       = jump_target;
            req_addr_next = jump_target;
          end else if (!stallIFIn && !flushIFIn) begin
            load_en       = 1'b1;
            load_inst     = imem.imemDataIn;
            load_pc       = req_addr;
            pc_next       = pc_inc;
            req_addr_next = pc_inc;
          end else begin
            buf_valid_next = 1'b1;
            buf_inst_next  = imem.imemDataIn;
            buf_pc_next    = req_addr;
            pc_next        = pc_inc;
            state_next     = IDLE;
          end
        end else if (jumpEnIn) begin
          pc_next    = jump_target;
          state_next = DRAIN;
        end
      end

      // The outstanding address is stale; keep it on the bus until its ack.
      DRAIN: begin
        if (jumpEnIn) begin
          pc_next = jump_target;
        end
        if (imem.imemAckIn) begin
          req_addr_next = jumpEnIn ? jump_target : pc;
          state_next    = REQ;
        end
      end

      IDLE: begin
        if (jumpEnIn) begin
          pc_next       = jump_target;
          req_addr_next = jump_target;
          state_next    = REQ;
        end else if (!stallIFIn) begin
          load_en        = 1'b1;
          load_inst      = buf_inst;
          load_pc        = buf_pc;
          buf_valid_next = 1'b0;
          req_addr_next  = pc;
          state_next     = REQ;
        end
      end

      default: begin
        state_next = REQ;
      end
    endcase
  end

  // Redirects and flushes always bubble IF/ID, even when a stall is requested.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instOut_IFID  <= NOP_INST;
      pcOut_IFID    <= '0;
      validOut_IFID <= 1'b0;
    end else if (flushIFIn || jumpEnIn) begin
      instOut_IFID  <= NOP_INST;
      pcOut_IFID    <= '0;
      validOut_IFID <= 1'b0;
    end else if (stallIFIn) begin
      instOut_IFID  <= instOut_IFID;
      pcOut_IFID    <= pcOut_IFID;
      validOut_IFID <= validOut_IFID;
    end else if (load_en) begin
      instOut_IFID  <= load_inst;
      pcOut_IFID    <= load_pc;
      validOut_IFID <= 1'b1;
    end else begin
      instOut_IFID  <= NOP_INST;
      pcOut_IFID    <= '0;
      validOut_IFID <= 1'b0;
    end
  end

endmodule
